instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Upstream neighbour of the instruction decoder/controller.
- Holds the program counter and issues one instruction-memory request at a time over a valid/ready request channel, with a separate response-valid return.
- Registers the returned word and presents it to decode as pc/instr plus pre-split opcode/funct3/funct7/rd/rs1/rs2 fields under a valid/ready handshake.
- Accepts redirects (taken branch, JAL, JALR) from execute and discards any wrong-path fetch.

Parameters:
- XLEN, 32, data/address width; fixed at 32, other values unsupported.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  request pending.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  read data valid; at most one per accepted request, at least 1 cycle after acceptance.
- imem_rdata  in  XLEN  instruction word.
- redirect_valid  in  1  execute requests PC change.
- redirect_pc  in  XLEN  new PC.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode/retire consumes instruction.
- out_pc  out  XLEN  PC of presented instruction.
- out_instr  out  XLEN  instruction word.
- out_opcode  out  7  instr[6:0].
- out_funct3  out  3  instr[14:12].
- out_funct7  out  7  instr[31:25].
- out_rd  out  5  instr[11:7].
- out_rs1  out  5  instr[19:15].
- out_rs2  out  5  instr[24:20].
- out_fault  out  1  misaligned-target fault; only with the optional feature, else tied 0.

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC, state=REQ, kill=0.
  - All outputs 0 except imem_addr=RESET_PC.
  - imem_req_valid rises 1 cycle after rst_n deasserts. Reset mid-transaction abandons it; a stale rsp arriving after reset is ignored by kill=0/state=REQ rules.
- States:
  - REQ: imem_req_valid=1, imem_addr=pc.
    - req_ready → WAIT.
    - imem_addr may change while not yet accepted.
  - WAIT: await imem_rsp_valid.
    - If kill=0: latch rdata into instr reg, out_pc=pc → FULL.
    - If kill=1: drop data, clear kill → REQ.
  - FULL: out_valid=1; instr/fields stable until accepted.
    - out_valid&out_ready: pc=pc+4 (mod 2^32 wrap) → REQ.
- Redirect (highest priority, every state):
  - REQ, not accepted: pc=redirect_pc, stay REQ.
  - REQ, accepted same cycle: set kill, pc=redirect_pc → WAIT.
  - WAIT: set kill, pc=redirect_pc. If rsp arrives the same cycle it is dropped, kill stays 0 → REQ.
  - FULL: instruction dropped (out_ready ignored), pc=redirect_pc → REQ.
- Only one outstanding request; imem_req_valid=0 outside REQ.
- Minimum latency: request accept → rsp (≥1 cycle) → out_valid the cycle after rsp. Back-to-back throughput is one instruction per 3 cycles with a 1-cycle memory.
- Field outputs are pure slices of the registered instr, all 0 when out_valid=0 after reset.
- Without the optional feature, redirect_pc[1:0] is forced to 2'b00.

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- Defined: a redirect with redirect_pc[1:0]!=0 issues no memory request. The block enters FULL with out_valid=1, out_fault=1, out_pc=redirect_pc, out_instr=32'h0000_0013 (NOP). On acceptance it stays stalled, out_valid=0, until the next redirect.
- Undefined: out_fault tied 0; low bits masked.

Decomposition:
- Shared package fetch_pkg:
  - state enum (REQ, WAIT, FULL, plus HALT under the feature).
  - NOP_INSTR constant 32'h0000_0013.
  - RESET_PC default.
  - Opcode constants shared with the controller.
- Sub-module instr_field_split: combinational slicing of instr into opcode/funct3/funct7/rd/rs1/rs2. Reused by the controller testbench.

Test Plan:
- Reset release, RESET_PC=0x100, 1-cycle memory returning 0x00500093, out_ready=1 → imem_addr 0x100, then 0x104. out_pc=0x100, out_opcode=0x13, out_rd=1.
- out_ready=0 for 5 cycles in FULL → out_* stable, imem_req_valid=0. On out_ready=1, next imem_addr=pc+4.
- redirect_valid to 0x200 while in WAIT with 3-cycle memory → returned word discarded (out_valid never 1 for it). Next request address 0x200.
- redirect_valid and out_ready both high in FULL at pc 0x40 → next imem_addr=redirect target, not 0x44.
- pc=0xFFFF_FFFC accepted → next imem_addr=0x0000_0000.
- With FETCH_MISALIGN_CHK_EN, redirect to 0x202 → no imem_req_valid, out_valid=1, out_fault=1, out_instr=0x00000013.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Types and constants shared by the instruction fetch unit, the field
// splitter and the decoder/controller.
//   - fetch_state_t    : fetch sequencer states (ST_HALT only with the
//                        FETCH_MISALIGN_CHK_EN build option)
//   - NOP_INSTR        : canonical NOP (addi x0, x0, 0)
//   - RESET_PC_DEFAULT : default reset program counter
//   - OPC_*            : base-ISA major opcodes
//   - align_word()     : clears the two low address bits
// Build option: FETCH_MISALIGN_CHK_EN adds the misaligned-target halt state.
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int unsigned XLEN_FIXED       = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_FULL = 2'd2
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    ST_HALT = 2'd3
`endif
  } fetch_state_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_field_split.sv
// ---------------------------------------------------------------------------
// instr_field_split
// Purely combinational slicing of a 32-bit instruction word into its
// standard fields.
// Ports:
//   instr  in  32  instruction word
//   opcode out 7   instr[6:0]
//   funct3 out 3   instr[14:12]
//   funct7 out 7   instr[31:25]
//   rd     out 5   instr[11:7]
//   rs1    out 5   instr[19:15]
//   rs2    out 5   instr[24:20]
// ---------------------------------------------------------------------------
module instr_field_split
  import fetch_pkg::*;
(
  input  logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Holds the PC, issues one instruction-memory request at a time, registers
// the returned word and presents it to decode under valid/ready. Redirects
// from execute take priority in every state; a fetch already in flight when
// a redirect arrives is marked killed and its response is dropped.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   imem_req_valid/ready, imem_addr   request channel (word-aligned address)
//   imem_rsp_valid, imem_rdata        response return
//   redirect_valid, redirect_pc       PC change from execute
//   out_valid/ready                   handshake to decode
//   out_pc, out_instr, out_opcode, out_funct3, out_funct7,
//   out_rd, out_rs1, out_rs2          presented instruction and fields
//   out_fault                         misaligned redirect target
// Build option: FETCH_MISALIGN_CHK_EN -- a redirect to a non-word-aligned
// target presents a faulting NOP instead of fetching, then halts until the
// next redirect. Without it out_fault is 0 and target low bits are cleared.
// ---------------------------------------------------------------------------
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [XLEN-1:0]  imem_rdata,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_instr,
  output logic [6:0]       out_opcode,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic             out_fault
);

  fetch_state_t     state_r;
  logic [XLEN-1:0]  pc_r;
  logic             kill_r;
  logic             req_valid_r;
  logic             out_valid_r;
  logic [XLEN-1:0]  out_pc_r;
  logic [XLEN-1:0]  instr_r;

  logic             req_fire_s;
  logic             restart_s;
  logic [XLEN-1:0]  redir_pc_s;
  logic [XLEN-1:0]  restart_pc_s;

`ifdef FETCH_MISALIGN_CHK_EN
  logic             fault_r;
  logic             restart_fault_s;

  assign redir_pc_s      = redirect_pc;
  assign restart_fault_s = |restart_pc_s[1:0];
  assign out_fault       = fault_r;
`else
  logic             unused_low_bits_s;

  assign redir_pc_s        = align_word(redirect_pc);
  assign unused_low_bits_s = ^redirect_pc[1:0];
  assign out_fault         = 1'b0;
`endif

  assign req_fire_s     = req_valid_r & imem_req_ready;
  // A restart always begins from the redirect target when one is present.
  assign restart_pc_s   = redirect_valid ? redir_pc_s : pc_r;

  assign imem_req_valid = req_valid_r;
  assign imem_addr      = pc_r;
  assign out_valid      = out_valid_r;
  assign out_pc         = out_pc_r;
  assign out_instr      = instr_r;

  // Decide when the sequencer abandons its current work and restarts fetch.
  always_comb begin
    restart_s = 1'b0;
    case (state_r)
      ST_REQ:  restart_s = redirect_valid & ~req_fire_s;
      // Killed response, or a redirect colliding with the response: drop it.
      ST_WAIT: restart_s = imem_rsp_valid & (kill_r | redirect_valid);
      ST_FULL: restart_s = redirect_valid;
`ifdef FETCH_MISALIGN_CHK_EN
      ST_HALT: restart_s = redirect_valid;
`endif
      default: restart_s = 1'b0;
    endcase
  end

  // Fetch sequencer: PC, kill flag, state and every registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_REQ;
      pc_r        <= RESET_PC;
      kill_r      <= 1'b0;
      req_valid_r <= 1'b0;
      out_valid_r <= 1'b0;
      out_pc_r    <= {XLEN{1'b0}};
      instr_r     <= {XLEN{1'b0}};
`ifdef FETCH_MISALIGN_CHK_EN
      fault_r     <= 1'b0;
`endif
    end else if (restart_s) begin
      pc_r   <= restart_pc_s;
      kill_r <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      if (restart_fault_s) begin
        // Misaligned target: present a faulting NOP without touching memory.
        state_r     <= ST_FULL;
        req_valid_r <= 1'b0;
        out_valid_r <= 1'b1;
        out_pc_r    <= restart_pc_s;
        instr_r     <= NOP_INSTR;
        fault_r     <= 1'b1;
      end else begin
        state_r     <= ST_REQ;
        req_valid_r <= 1'b1;
        out_valid_r <= 1'b0;
        fault_r     <= 1'b0;
      end
`else
      state_r     <= ST_REQ;
      req_valid_r <= 1'b1;
      out_valid_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_REQ: begin
          if (req_fire_s) begin
            // A redirect in the accept cycle leaves this fetch wrong-path.
            state_r     <= ST_WAIT;
            req_valid_r <= 1'b0;
            kill_r      <= redirect_valid;
            if (redirect_valid) begin
              pc_r <= redir_pc_s;
            end
          end else begin
            // Also raises the request the first cycle after reset release.
            req_valid_r <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            state_r     <= ST_FULL;
            instr_r     <= imem_rdata;
            out_pc_r    <= pc_r;
            out_valid_r <= 1'b1;
          end else if (redirect_valid) begin
            kill_r <= 1'b1;
            pc_r   <= redir_pc_s;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            if (fault_r) begin
              state_r <= ST_HALT;
            end else begin
              state_r     <= ST_REQ;
              req_valid_r <= 1'b1;
              pc_r        <= pc_r + 32'd4;
            end
`else
            state_r     <= ST_REQ;
            req_valid_r <= 1'b1;
            pc_r        <= pc_r + 32'd4;
`endif
          end
        end
`ifdef FETCH_MISALIGN_CHK_EN
        ST_HALT: begin
          out_valid_r <= 1'b0;
        end
`endif
        default: begin
          state_r     <= ST_REQ;
          req_valid_r <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  instr_field_split u_split (
    .instr  (instr_r),
    .opcode (out_opcode),
    .funct3 (out_funct3),
    .funct7 (out_funct7),
    .rd     (out_rd),
    .rs1    (out_rs1),
    .rs2    (out_rs2)
  );

endmodule
